spi_xfer_sequencer: RTL

//  SPI master transaction sequencer that drives the SPI clock controller.
//  - Accepts one word per transaction through a valid/ready handshake.
//  - Generates the base serial clock (sck_base) and its gate (sck_en). The clock

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sck_divider.sv | 19 +
 rtl/spi_xfer_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and SPI mode codes for the transaction sequencer
package spi_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;
  // {CKE,CKP} codes understood by the pad clock controller
  localparam logic [1:0] MODE0 = 2'b10;
  localparam logic [1:0] MODE1 = 2'b00;
  localparam logic [1:0] MODE2 = 2'b11;
  localparam logic [1:0] MODE3 = 2'b01;
endpackage

// File: rtl/spi_sck_divider.sv
// spi_sck_divider: half-period down-counter emitting a one-cycle tick per expiry
module spi_sck_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && !load && cnt == '0;
  // count div..0, reloading on load or on expiry so every half-period has the same length
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load || tick) cnt <= div;
    else if (en) cnt <= cnt - DIV_W'(1);
endmodule

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: SPI master transaction sequencer feeding the pad clock controller
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic              miso,
  output logic              sck_base,
  output logic              sck_en,
  output logic              mosi,
  output logic              cs_n,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy
);
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W - 1);
  state_t            state;
  logic [DIV_W-1:0]  div_lat, div_m1;
  logic              cpha, lsb, tick, start, lead, adv, smp;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [EW-1:0]     edge_cnt;
  assign tx_ready = state == IDLE;
  assign busy     = !tx_ready;
  assign start    = tx_valid && tx_ready;
  // the divider loads the fresh config at handshake, then reloads from the latched copy
  assign div_m1   = start ? (cfg_div == '0 ? '0 : cfg_div - DIV_W'(1)) : div_lat;
  assign lead     = !edge_cnt[0];
  assign adv      = tick && state == XFER && (cpha ? lead && edge_cnt != '0 : !lead && edge_cnt != LAST);
  assign smp      = tick && state == XFER && (cpha ? !lead : lead);
  spi_sck_divider #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .load (start),
    .en   (state != IDLE),
    .div  (div_m1),
    .tick (tick)
  );
  // transaction FSM with shift registers, edge counter and registered pad outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      sck_base <= 1'b0;
      sck_en   <= 1'b0;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      div_lat  <= '0;
      cpha     <= 1'b0;
      lsb      <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= SETUP;
          cs_n     <= 1'b0;
          div_lat  <= div_m1;
          cpha     <= cfg_cpha;
          lsb      <= cfg_lsb_first;
          tx_sh    <= tx_data;
          mosi     <= cfg_lsb_first ? tx_data[0] : tx_data[DATA_W-1];
          edge_cnt <= '0;
        end
        SETUP: if (tick) begin
          state  <= XFER;
          sck_en <= 1'b1;
        end
        XFER: if (tick) begin
          sck_base <= !sck_base;
          edge_cnt <= edge_cnt + EW'(1);
          if (edge_cnt == LAST) begin
            state  <= HOLD;
            sck_en <= 1'b0;
          end
          if (adv) begin
            mosi  <= lsb ? tx_sh[1] : tx_sh[DATA_W-2];
            tx_sh <= lsb ? tx_sh >> 1 : tx_sh << 1;
          end
          if (smp) rx_sh <= lsb ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        end
        HOLD: if (tick) begin
          state    <= IDLE;
          cs_n     <= 1'b1;
          mosi     <= 1'b0;
          rx_valid <= 1'b1;
          rx_data  <= rx_sh;
        end
      endcase
    end
endmodule
